// File: rtl/axi_lite_arbiter.sv
//------------------------------------------------------------------------------
// axi_lite_arbiter : two-master (fetch / LSU), one-slave arbiter for the shared SRAM.
// Optional round-robin fairness between masters: define ARB_ROUND_ROBIN_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axi_lite_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [63:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  input  logic [63:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [63:0] m1_rdata,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  input  logic [63:0] m1_waddr,
  input  logic [63:0] m1_wdata,
  input  logic [7:0]  m1_w_shifter,
  input  logic [7:0]  m1_w_DWHB,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  output logic [63:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [63:0] s_rdata,
  input  logic        s_rvalid,
  output logic        s_rready,
  output logic [63:0] s_waddr,
  output logic [63:0] s_wdata,
  output logic [7:0]  s_w_shifter,
  output logic [7:0]  s_w_DWHB,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic        s_bvalid,
  output logic        s_bready
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_m0_rd = 2'd1;
  localparam logic [1:0] c_m1_rd = 2'd2;
  localparam logic [1:0] c_m1_wr = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_addr_done;
  logic       w_addr_done_nxt;
  logic       w_m1_req;
  logic       w_prefer_m0;
  logic       w_gnt_valid;
  logic       w_addr_hs;
  logic       w_resp_hs;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic c_grant_m0 = 1'b0;
  localparam logic c_grant_m1 = 1'b1;

  logic r_last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= c_grant_m1;
    end else if (r_state == c_idle && w_state_nxt != c_idle) begin
      r_last_grant <= (w_state_nxt == c_m0_rd) ? c_grant_m0 : c_grant_m1;
    end
  end

  assign w_prefer_m0 = (r_last_grant == c_grant_m1);
`else
  assign w_prefer_m0 = 1'b0;
`endif

  assign w_m1_req  = m1_wvalid | m1_arvalid;
  assign w_addr_hs = (s_arvalid & s_arready) | (s_wvalid & s_wready);
  assign w_resp_hs = (s_rvalid & s_rready) | (s_bvalid & s_bready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_idle;
      r_addr_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr_done <= w_addr_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_done_nxt = r_addr_done;
    w_gnt_valid     = 1'b0;
    case (r_state)
      c_m0_rd: w_gnt_valid = m0_arvalid;
      c_m1_rd: w_gnt_valid = m1_arvalid;
      c_m1_wr: w_gnt_valid = m1_wvalid;
      default: w_gnt_valid = 1'b0;
    endcase
    if (r_state == c_idle) begin
      w_addr_done_nxt = 1'b0;
      // Within M1 a write always beats a read; between masters fairness may override.
      if (w_m1_req && !(m0_arvalid && w_prefer_m0)) begin
        w_state_nxt = m1_wvalid ? c_m1_wr : c_m1_rd;
      end else if (m0_arvalid) begin
        w_state_nxt = c_m0_rd;
      end
    end else if (!r_addr_done) begin
      // A master withdrawing its request before the address handshake cancels it.
      if (!w_gnt_valid) begin
        w_state_nxt = c_idle;
      end else if (w_addr_hs) begin
        w_addr_done_nxt = 1'b1;
      end
    end else if (w_resp_hs) begin
      w_state_nxt     = c_idle;
      w_addr_done_nxt = 1'b0;
    end
  end

  always_comb begin
    m0_arready  = 1'b0;
    m0_rdata    = 64'd0;
    m0_rvalid   = 1'b0;
    m1_arready  = 1'b0;
    m1_rdata    = 64'd0;
    m1_rvalid   = 1'b0;
    m1_wready   = 1'b0;
    m1_bvalid   = 1'b0;
    s_araddr    = 64'd0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    s_waddr     = 64'd0;
    s_wdata     = 64'd0;
    s_w_shifter = 8'd0;
    s_w_DWHB    = 8'd0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    case (r_state)
      c_m0_rd: begin
        if (!r_addr_done) begin
          s_araddr   = m0_araddr;
          s_arvalid  = m0_arvalid;
          m0_arready = s_arready;
        end else begin
          m0_rdata  = s_rdata;
          m0_rvalid = s_rvalid;
          s_rready  = m0_rready;
        end
      end
      c_m1_rd: begin
        if (!r_addr_done) begin
          s_araddr   = m1_araddr;
          s_arvalid  = m1_arvalid;
          m1_arready = s_arready;
        end else begin
          m1_rdata  = s_rdata;
          m1_rvalid = s_rvalid;
          s_rready  = m1_rready;
        end
      end
      c_m1_wr: begin
        if (!r_addr_done) begin
          s_waddr     = m1_waddr;
          s_wdata     = m1_wdata;
          s_w_shifter = m1_w_shifter;
          s_w_DWHB    = m1_w_DWHB;
          s_wvalid    = m1_wvalid;
          m1_wready   = s_wready;
        end else begin
          m1_bvalid = s_bvalid;
          s_bready  = m1_bready;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire
